// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and widths for the evict data path.
// Lines travel as ram_to_evdb_pld_t and leave as BUS_WIDTH beats of evict_to_ds_pld_t.
package vector_cache_pkg;

  localparam int BUS_WIDTH            = 128;
  localparam int LINE_WIDTH           = 1024;
  localparam int MSHR_ENTRY_IDX_WIDTH = 4;
  localparam int DB_ENTRY_IDX_WIDTH   = 3;
  localparam int TXNID_WIDTH          = 12;
  localparam int SIDEBAND_WIDTH       = 8;
  localparam int EVICT_BEATS          = 1024 / BUS_WIDTH;

  typedef struct packed {
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
  } evict_req_pld_t;

  typedef struct packed {
    logic [LINE_WIDTH-1:0] data;
    evict_req_pld_t        evict_req_pld;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0]            data;
    logic                            last;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } evict_to_ds_pld_t;

  typedef struct packed {
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
  } evict_done_pld_t;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } evict_ser_state_e;

endpackage

// File: rtl/evict_line_fifo.sv
// Generic DEPTH-entry payload FIFO; head is a combinational read of the rd_ptr slot, count updates one cycle after push/pop.
// Backpressure: push while full and pop while empty are ignored, so callers gate on full/empty.
module evict_line_fifo
  import vector_cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/evict_data_serializer.sv
// Splits buffered 1024-bit evict lines into BUS_W beats with last; beat 0 one cycle after push, one-cycle done pulse after the final beat.
// Beats hold stable under downstream stall; evdb_in_rdy is registered-only (count < DEPTH) with no path from evict_ds_rdy.
module evict_data_serializer
  import vector_cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 1024,
  parameter int BUS_W  = BUS_WIDTH,
  parameter int BEATS  = LINE_W / BUS_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                evdb_in_vld,
  output logic                                evdb_in_rdy,
  input  logic [$bits(ram_to_evdb_pld_t)-1:0] evdb_in_pld,
  output logic                                evict_ds_vld,
  input  logic                                evict_ds_rdy,
  output logic [$bits(evict_to_ds_pld_t)-1:0] evict_ds_pld,
  output logic                                evict_done_vld,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0]     evict_done_rob_id,
  output logic [DB_ENTRY_IDX_WIDTH-1:0]       evict_done_db_id
);

  localparam int ENTRY_W = $bits(ram_to_evdb_pld_t);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [ENTRY_W-1:0] head_dat;
  ram_to_evdb_pld_t   head;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               beat_hs;
  logic               is_last;
  evict_ser_state_e   state;
  evict_ser_state_e   state_nxt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_nxt;
  logic [BUS_W-1:0]   beat_dat [BEATS];
  evict_to_ds_pld_t   ds_pld;
  evict_done_pld_t    done_pld;

  evict_line_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_line_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (evdb_in_pld),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign head        = ram_to_evdb_pld_t'(head_dat);
  assign evdb_in_rdy = !fifo_full;
  assign push        = evdb_in_vld && evdb_in_rdy;

  assign evict_ds_vld = (state == SER_SEND);
  assign is_last      = (beat_cnt == BEAT_W'(BEATS - 1));
  assign beat_hs      = evict_ds_vld && evict_ds_rdy;
  assign pop          = beat_hs && is_last && !fifo_empty;
  assign count_nxt    = count + CNT_W'(push) - CNT_W'(pop);

  for (genvar i = 0; i < BEATS; i++) begin : g_beat
    assign beat_dat[i] = head.data[i*BUS_W +: BUS_W];
  end

  // Entering SEND on the push itself is what gives beat 0 the cycle after the line arrives.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    unique case (state)
      SER_IDLE: begin
        if (count_nxt != '0) state_nxt = SER_SEND;
      end
      SER_SEND: begin
        if (beat_hs) begin
          if (is_last) begin
            beat_nxt = '0;
            if (count_nxt == '0) state_nxt = SER_IDLE;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SER_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    ds_pld              = '0;
    ds_pld.data         = beat_dat[beat_cnt];
    ds_pld.last         = is_last;
    ds_pld.rob_entry_id = head.evict_req_pld.rob_entry_id;
    ds_pld.db_entry_id  = head.evict_req_pld.db_entry_id;
    ds_pld.txnid        = head.evict_req_pld.txnid;
    ds_pld.sideband     = head.evict_req_pld.sideband;
  end

  assign evict_ds_pld = ds_pld;

  always_ff @(posedge clk) begin
    if (rst) begin
      evict_done_vld <= 1'b0;
      done_pld       <= '0;
    end else begin
      evict_done_vld <= pop;
      if (pop) begin
        done_pld.rob_entry_id <= head.evict_req_pld.rob_entry_id;
        done_pld.db_entry_id  <= head.evict_req_pld.db_entry_id;
      end
    end
  end

  assign evict_done_rob_id = done_pld.rob_entry_id;
  assign evict_done_db_id  = done_pld.db_entry_id;

endmodule

// File: tb/tb_evict_data_serializer.sv
// Randomized bench for evict_data_serializer against a queue-of-lines reference model.
module tb_evict_data_serializer;
  import vector_cache_pkg::*;

  localparam int DEPTH = 4;
  localparam int NB    = 1024 / 128;

  logic                                clk;
  logic                                rst;
  logic                                evdb_in_vld;
  logic                                evdb_in_rdy;
  ram_to_evdb_pld_t                    evdb_in_pld;
  logic                                evict_ds_vld;
  logic                                evict_ds_rdy;
  logic [$bits(evict_to_ds_pld_t)-1:0] evict_ds_pld;
  logic                                evict_done_vld;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0]     evict_done_rob_id;
  logic [DB_ENTRY_IDX_WIDTH-1:0]       evict_done_db_id;

  evict_data_serializer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .evdb_in_vld       (evdb_in_vld),
    .evdb_in_rdy       (evdb_in_rdy),
    .evdb_in_pld       (evdb_in_pld),
    .evict_ds_vld      (evict_ds_vld),
    .evict_ds_rdy      (evict_ds_rdy),
    .evict_ds_pld      (evict_ds_pld),
    .evict_done_vld    (evict_done_vld),
    .evict_done_rob_id (evict_done_rob_id),
    .evict_done_db_id  (evict_done_db_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: lines accepted but not yet fully sent, oldest first.
  ram_to_evdb_pld_t exp_q[$];
  int               beat_idx   = 0;
  bit               done_pend  = 0;
  logic [3:0]       done_rob   = '0;
  logic [2:0]       done_db    = '0;
  int               done_seen  = 0;
  int               beats_acc  = 0;
  bit               stall_prev = 0;
  logic [$bits(evict_to_ds_pld_t)-1:0] held_pld;

  int rdy_mode = 0;
  int pat_idx  = 0;

  always @(negedge clk) begin : mon
    evict_to_ds_pld_t o;
    ram_to_evdb_pld_t cur;
    int occ;
    o = evict_to_ds_pld_t'(evict_ds_pld);
    if (rst) begin
      exp_q.delete();
      beat_idx   = 0;
      done_pend  = 0;
      stall_prev = 0;
    end else begin
      occ = exp_q.size();
      check("in_rdy", evdb_in_rdy, occ < DEPTH);
      check("ds_vld", evict_ds_vld, occ > 0);
      check("done_vld", evict_done_vld, done_pend);
      if (evict_done_vld) done_seen++;
      if (done_pend) begin
        check("done_rob", evict_done_rob_id, done_rob);
        check("done_db", evict_done_db_id, done_db);
      end
      done_pend = 0;
      if (stall_prev) check("hold_pld", evict_ds_pld, held_pld);
      stall_prev = 0;
      if (occ > 0) begin
        cur = exp_q[0];
        check("beat_data", o.data, cur.data[beat_idx*128 +: 128]);
        check("beat_last", o.last, beat_idx == NB - 1);
        check("beat_rob", o.rob_entry_id, cur.evict_req_pld.rob_entry_id);
        check("beat_db", o.db_entry_id, cur.evict_req_pld.db_entry_id);
        check("beat_txn", o.txnid, cur.evict_req_pld.txnid);
        check("beat_sb", o.sideband, cur.evict_req_pld.sideband);
        if (evict_ds_rdy) begin
          beats_acc++;
          if (beat_idx == NB - 1) begin
            done_pend = 1;
            done_rob  = cur.evict_req_pld.rob_entry_id;
            done_db   = cur.evict_req_pld.db_entry_id;
            void'(exp_q.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end else begin
          stall_prev = 1;
          held_pld   = evict_ds_pld;
        end
      end
      if (evdb_in_vld && occ < DEPTH) exp_q.push_back(evdb_in_pld);
    end
  end

  // Downstream ready: 0 always 1, 1 always 0, 2 pattern 1,0,0,1, 3 random.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    evict_ds_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: evict_ds_rdy = 1'b1;
        1: evict_ds_rdy = 1'b0;
        2: begin evict_ds_rdy = pat[pat_idx % 4]; pat_idx++; end
        default: evict_ds_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [1023:0] rand_line();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_line(input logic [1023:0] d, input logic [3:0] rob, input logic [2:0] db);
    int n;
    logic acc;
    evdb_in_pld.data                       = d;
    evdb_in_pld.evict_req_pld.rob_entry_id = rob;
    evdb_in_pld.evict_req_pld.db_entry_id  = db;
    evdb_in_pld.evict_req_pld.txnid        = 12'($urandom);
    evdb_in_pld.evict_req_pld.sideband     = 8'($urandom);
    evdb_in_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = evdb_in_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    evdb_in_vld = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_pend) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || done_pend) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1023:0] d;
    int d0;
    int b0;
    int n;
    rst         = 1'b1;
    evdb_in_vld = 1'b0;
    evdb_in_pld = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", evdb_in_rdy, 1);
    check("rst_ds_vld", evict_ds_vld, 0);
    check("rst_done_vld", evict_done_vld, 0);
    check("rst_done_rob", evict_done_rob_id, 0);
    check("rst_done_db", evict_done_db_id, 0);
    @(posedge clk);
    #1;

    // 1: single line, byte-pattern beats
    rdy_mode = 0;
    for (int i = 0; i < NB; i++) d[i*128 +: 128] = {16{8'(i)}};
    d0 = done_seen;
    push_line(d, 4'd5, 3'd3);
    wait_drain();
    check("single_done_cnt", done_seen - d0, 1);

    // 2: backpressure pattern
    rdy_mode = 2;
    pat_idx  = 0;
    b0 = beats_acc;
    push_line(rand_line(), 4'd9, 3'd1);
    wait_drain();
    check("bp_beats", beats_acc - b0, NB);

    // 3: fill with downstream stalled, release later
    rdy_mode = 1;
    fork
      begin
        for (int i = 0; i < 5; i++) push_line(rand_line(), 4'(i), 3'(i));
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    wait_drain();

    // 4: back-to-back lines
    rdy_mode = 0;
    d0 = done_seen;
    for (int i = 0; i < 3; i++) push_line(rand_line(), 4'(10 + i), 3'(4 + i));
    wait_drain();
    check("b2b_done_cnt", done_seen - d0, 3);

    // 5: wrap-around with random downstream ready
    rdy_mode = 3;
    d0 = done_seen;
    for (int i = 0; i < 10; i++) begin
      push_line(rand_line(), 4'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_drain();
    check("wrap_done_cnt", done_seen - d0, 10);

    // 6: reset partway through line 0 with a second line queued
    rdy_mode = 0;
    push_line(rand_line(), 4'd7, 3'd2);
    push_line(rand_line(), 4'd8, 3'd6);
    n = 0;
    while (beat_idx != 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reset_reach_beat3", beat_idx, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_seen;
    @(negedge clk);
    check("midrst_ds_vld", evict_ds_vld, 0);
    check("midrst_in_rdy", evdb_in_rdy, 1);
    check("midrst_done_vld", evict_done_vld, 0);
    @(posedge clk);
    #1;
    push_line(rand_line(), 4'd1, 3'd1);
    wait_drain();
    check("midrst_done_cnt", done_seen - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evict_data_serializer.md
Name: evict_data_serializer

Overview:
- Transmit end of the evict data path. Accepts full 1024-bit evict lines (ram_to_evdb_pld_t) read out of the data RAMs.
- Buffers them in a small FIFO and emits each line as BUS_WIDTH-bit beats (evict_to_ds_pld_t) with `last` to the downstream port.
- Pulses a completion indication carrying rob_entry_id and db_entry_id when the final beat is accepted, so the MSHR/EVDB can free the entry.

Parameters:
- DEPTH, 4, number of buffered 1024-bit lines; power of two, >= 2.
- LINE_W, 1024, line width in bits.
- BUS_W, BUS_WIDTH (128), beat width.
- BEATS, LINE_W/BUS_W (8), beats per line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- evdb_in_vld  in  1  input line valid.
- evdb_in_rdy  out  1  input line ready.
- evdb_in_pld  in  $bits(ram_to_evdb_pld_t)  data plus evict_req_pld.
- evict_ds_vld  out  1  beat valid.
- evict_ds_rdy  in  1  downstream ready.
- evict_ds_pld  out  $bits(evict_to_ds_pld_t)  data, last, rob_entry_id, db_entry_id, txnid, sideband.
- evict_done_vld  out  1  one-cycle pulse: final beat of a line accepted.
- evict_done_rob_id  out  MSHR_ENTRY_IDX_WIDTH  rob_entry_id of the finished line.
- evict_done_db_id  out  DB_ENTRY_IDX_WIDTH  db_entry_id of the finished line.

Behaviour:
- Reset: all listed below are cleared while rst is high and on the first cycle after.
  - wr_ptr, rd_ptr, count, beat_cnt cleared; state=IDLE.
  - evdb_in_rdy=1 after reset; evict_ds_vld=0; evict_done_vld=0; done ids=0.
  - Storage array is not reset.
- Input handshake:
  - evdb_in_rdy = (count < DEPTH), driven from registers only; no combinational path from evict_ds_rdy.
  - Push on vld&&rdy: store data plus metadata (rob_entry_id, db_entry_id, txnid, sideband from evict_req_pld) at wr_ptr; wr_ptr++ modulo DEPTH.
- Latency: a line pushed in cycle N can present beat 0 at the output in cycle N+1 at the earliest.
- State machine:
  - IDLE: evict_ds_vld=0. Go to SEND when count>0.
  - SEND: evict_ds_vld=1. Output shows the head entry (rd_ptr), beat_cnt selects the beat.
    - data = line[beat_cnt*BUS_W +: BUS_W]; beat 0 carries the LSBs.
    - last = (beat_cnt == BEATS-1).
    - On evict_ds_vld&&evict_ds_rdy with !last: beat_cnt++.
    - On an accepted last beat: beat_cnt=0, rd_ptr++ modulo DEPTH, pop the entry, assert evict_done pulse next cycle with that entry's ids.
    - After the pop, stay in SEND if the remaining count (after a same-cycle push) is >0; else go to IDLE.
- Stability: while vld&&!rdy, evict_ds_pld is held bit-stable and vld stays high. The output is withdrawn only by rst.
- Back-to-back: no bubble between lines when the next entry is present; beat 0 of line k+1 follows the last beat of line k in the next cycle.
- Simultaneous push and final-beat pop in the same cycle: count unchanged.
  - When full, rdy is 0 that cycle (no same-cycle slot reuse). The push is accepted the following cycle.
- Pointers use log2(DEPTH) bits and wrap naturally. count uses log2(DEPTH)+1 bits and is never beyond 0..DEPTH.
- Reset mid-line: the partial line and all buffered lines are dropped. No evict_done pulse is produced for them.
- evict_done_vld is exactly one pulse per line, registered one cycle after the final-beat handshake.

Decomposition:
- vector_cache_pkg already holds ram_to_evdb_pld_t, evict_to_ds_pld_t, BUS_WIDTH and the index widths.
- Add EVICT_BEATS = 1024/BUS_WIDTH to the package.
- Add an evict_done_pld_t struct {rob_entry_id, db_entry_id} to the package.
- One natural sub-module, evict_line_fifo: a generic DEPTH-entry payload FIFO with push/pop/count. The serializer FSM and beat mux stay in the top.

Test Plan:
1. Single line with data[i*128+:128] = {16{8'(i)}}, rob=5, db=3, ds_rdy=1. Expect 8 consecutive beats, beat i = {16{8'(i)}}, last only on beat 7, then a done pulse with rob=5, db=3 one cycle later. Input pushed at cycle 0 gives beat 0 at cycle 1.
2. Backpressure: ds_rdy toggles 1,0,0,1,… Expect each beat held stable during the stall, no beat skipped or duplicated, 8 accepted beats total.
3. Fill: push 5 lines with ds_rdy=0. Expect rdy to drop after the 4th push. The 5th is accepted only after line 0's last beat, with rdy rising the cycle after that pop.
4. Back-to-back: 3 lines, ds_rdy=1. Expect 24 contiguous valid beats, no bubbles, 3 done pulses in order with the correct ids.
5. Wrap-around: stream 10 lines through DEPTH=4 with random ds_rdy. Expect output data/ids to match input order exactly, and count never to exceed 4.
6. Reset at beat 3 of line 0 with 2 lines queued. Expect the next cycle vld=0, rdy=1, no done pulse. A fresh line afterwards starts at beat 0.
